// File: rtl/ldpc_pkg.sv
// ldpc_pkg -- shared constants and types for the systematic LDPC encoder.
//   DEF_INFO_LEN / DEF_PAR_LEN : default information / parity bit counts
//   DEF_QUAN_WIDTH / DEF_LLR_MAG : default LLR symbol width and magnitude
//   P_MATRIX   : parity-generator rows; bit j of row i feeds parity bit p_j
//   state_e    : encoder FSM states (IDLE, ACCUM, OUT)
//   p_row()    : bounds-safe lookup of one P_MATRIX row
package ldpc_pkg;

  localparam int DEF_INFO_LEN   = 4;
  localparam int DEF_PAR_LEN    = 4;
  localparam int DEF_QUAN_WIDTH = 10;
  localparam int DEF_LLR_MAG    = 64;

  localparam logic [DEF_PAR_LEN-1:0] P_MATRIX [DEF_INFO_LEN] = '{
    4'b1011,  // u0
    4'b1101,  // u1
    4'b0111,  // u2
    4'b1110   // u3
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_OUT   = 2'd2
  } state_e;

  // Rows beyond the table contribute nothing, so an out-of-range index
  // cannot pull in X or a wrapped row.
  function automatic logic [DEF_PAR_LEN-1:0] p_row(input int i);
    if (i >= 0 && i < DEF_INFO_LEN) return P_MATRIX[i];
    return '0;
  endfunction

endpackage

// File: rtl/ldpc_llr_map.sv
// ldpc_llr_map -- maps one code bit to a signed channel LLR symbol.
//   bit_in : code bit (0 -> +LLR_MAG, 1 -> -LLR_MAG)
//   llr    : quan_width-bit two's-complement LLR; its MSB equals bit_in
//            whenever LLR_MAG fits in quan_width-1 bits.
module ldpc_llr_map #(
  parameter int quan_width = 10,
  parameter int LLR_MAG    = 64
) (
  input  logic                  bit_in,
  output logic [quan_width-1:0] llr
);

  localparam logic [quan_width-1:0] POS = quan_width'(LLR_MAG);
  localparam logic [quan_width-1:0] NEG = quan_width'(-LLR_MAG);

  assign llr = bit_in ? NEG : POS;

endmodule

// File: rtl/ldpc_encoder.sv
// ldpc_encoder -- bit-serial systematic LDPC encoder with LLR mapping.
//   clk, rst        : clock; asynchronous active-low reset
//   in_valid/in_ready/in_data : info word input (INFO_LEN bits, u[i] = bit i)
//   out_valid/out_ready       : codeword output handshake
//   cw              : {parity, u}
//   L               : per-code-bit LLR, slice k belongs to cw[k]
//   busy            : high whenever the FSM is not idle
//   syn_err         : syndrome-check failure flag
//   dbg_state       : current FSM state (state_e encoding)
// Optional feature: define LDPC_ENC_CHECK_EN to build the syndrome checker;
// without it syn_err is a constant 0.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; in_valid is ignored elsewhere.
// out_valid stays high with cw/L/syn_err frozen until out_ready is seen.
module ldpc_encoder
  import ldpc_pkg::*;
#(
  parameter int INFO_LEN   = DEF_INFO_LEN,
  parameter int PAR_LEN    = DEF_PAR_LEN,
  parameter int quan_width = DEF_QUAN_WIDTH,
  parameter int LLR_MAG    = DEF_LLR_MAG,
  localparam int CODE_LEN  = INFO_LEN + PAR_LEN,
  localparam int CNT_W     = $clog2(INFO_LEN) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [INFO_LEN-1:0]            in_data,
  output logic                           in_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CODE_LEN-1:0]            cw,
  output logic [CODE_LEN*quan_width-1:0] L,
  output logic                           busy,
  output logic                           syn_err,
  output logic [1:0]                     dbg_state
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ACCUM = ST_ACCUM;
  localparam logic [1:0] S_OUT   = ST_OUT;

  logic [1:0]                     state;
  logic [INFO_LEN-1:0]            u_reg;
  logic [PAR_LEN-1:0]             parity;
  logic [CNT_W-1:0]               cnt;
  logic                           cur_bit;
  logic [PAR_LEN-1:0]             row;
  logic                           accum_done;
  logic [CODE_LEN-1:0]            cw_next;
  logic [CODE_LEN*quan_width-1:0] l_next;

  // Counter runs 0..INFO_LEN: values below INFO_LEN each fold one info bit,
  // the extra count is the cycle that registers the finished codeword.
  assign accum_done = (cnt >= CNT_W'(INFO_LEN));
  assign cur_bit    = |(u_reg & (INFO_LEN'(1) << cnt));
  assign row        = PAR_LEN'(p_row(int'(cnt)));
  assign cw_next    = {parity, u_reg};

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  for (genvar k = 0; k < CODE_LEN; k++) begin : g_llr
    ldpc_llr_map #(
      .quan_width(quan_width),
      .LLR_MAG   (LLR_MAG)
    ) u_map (
      .bit_in(cw_next[k]),
      .llr   (l_next[k*quan_width +: quan_width])
    );
  end

`ifdef LDPC_ENC_CHECK_EN
  // Syndrome of {p, u} against H = [P^T | I]: re-derive every parity bit
  // from u and compare with the accumulated register.
  logic [PAR_LEN-1:0] syndrome;
  logic               syn_err_q;

  always_comb begin
    syndrome = parity;
    for (int i = 0; i < INFO_LEN; i++) begin
      if (u_reg[i]) syndrome = syndrome ^ PAR_LEN'(p_row(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      syn_err_q <= 1'b0;
    end else if (state == S_ACCUM && accum_done) begin
      syn_err_q <= |syndrome;
    end else if (state == S_OUT && out_ready) begin
      syn_err_q <= 1'b0;
    end
  end

  assign syn_err = syn_err_q;
`else
  assign syn_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      u_reg     <= '0;
      parity    <= '0;
      cnt       <= '0;
      cw        <= '0;
      L         <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            u_reg  <= in_data;
            parity <= '0;
            cnt    <= '0;
            state  <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (!accum_done) begin
            if (cur_bit) parity <= parity ^ row;
            cnt <= cnt + CNT_W'(1);
          end else begin
            cw        <= cw_next;
            L         <= l_next;
            out_valid <= 1'b1;
            state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
